pingpong_burst_buf: RTL and testbench

Parametrised two-bank burst buffer between a bursting producer (a-side) and a bursting consumer (b-side). Accepts bursts of up to BURST_LEN words with a full valid/ready handshake. Each burst is written into one RAM bank while the other bank is streamed out, giving continuous one-beat-per-cycle throughput. Replaces the fixed-length, single-bank, write-then-read bus buffer and adds:

- early-terminated bursts (a_last)
- b-side back-pressure
- output burst framing (b_last)

---
 rtl/pingpong_burst_buf_pkg.sv | 17 +
 rtl/pingpong_burst_buf_ram.sv | 22 ++
 rtl/pingpong_burst_buf.sv | 155 +++++++++++++++
 tb/tb_pingpong_burst_buf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_burst_buf_pkg.sv
// Shared types for the two-bank burst buffer: per-bank state and bank selector.
package pingpong_burst_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  typedef logic bank_sel_t;

  function automatic bank_sel_t other_bank(input bank_sel_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/pingpong_burst_buf_ram.sv
// Simple dual-port storage for both banks; address is {bank, word}.
module burst_buf_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/pingpong_burst_buf.sv
// Ping-pong burst buffer: one bank fills from the a-side while the other
// streams out through a 1-cycle RAM read and a 2-entry skid buffer.
module pingpong_burst_buf
  import pingpong_burst_buf_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  input  logic              a_last,
  output logic              a_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  output logic              b_last,
  input  logic              b_ready,
  output logic [1:0]        bank_full
);

  localparam int ADDR_W = $clog2(BURST_LEN);
  localparam int LEN_W  = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BURST_LEN - 1);

  bank_state_t       state_q [2];
  logic [LEN_W-1:0]  len_q [2];
  bank_sel_t         wr_bank_q, rd_bank_q, free_bank_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic              rd_busy_q;
  logic              infl_q, infl_last_q;
  logic [DATA_W-1:0] skid_data_q [2];
  logic              skid_last_q [2];
  logic              skid_head_q, skid_tail_q;
  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic [DATA_W-1:0] ram_rdata;

  logic       a_fire, wr_close, b_fire, b_free;
  logic       rd_avail, rd_issue, rd_issue_last;
  logic [1:0] occ_after;

  assign a_ready  = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
  assign a_fire   = a_valid && a_ready;
  assign wr_close = a_fire && (a_last || (wr_addr_q == LAST_ADDR));

  assign b_valid = (skid_cnt_q != 2'd0);
  assign b_data  = skid_data_q[skid_head_q];
  assign b_last  = b_valid && skid_last_q[skid_head_q];
  assign b_fire  = b_valid && b_ready;
  assign b_free  = b_fire && skid_last_q[skid_head_q];

  // Counting the beat leaving this cycle keeps one read per cycle flowing
  // while still bounding skid entries plus in-flight reads to two.
  assign skid_cnt_d    = skid_cnt_q + 2'(infl_q) - 2'(b_fire);
  assign occ_after     = skid_cnt_d;
  assign rd_avail      = rd_busy_q || (state_q[rd_bank_q] == FULL);
  assign rd_issue      = rd_avail && (occ_after < 2'd2);
  assign rd_issue_last = ((LEN_W'(rd_addr_q) + LEN_W'(1)) == len_q[rd_bank_q]);

  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign bank_full[gi] = (state_q[gi] == FULL) || (state_q[gi] == DRAINING);
  end

  burst_buf_ram #(.DATA_W(DATA_W), .AW(ADDR_W + 1)) u_ram (
    .clk       (clk),
    .wr_en_i   (a_fire),
    .wr_addr_i ({wr_bank_q, wr_addr_q}),
    .wr_data_i (a_data),
    .rd_en_i   (rd_issue),
    .rd_addr_i ({rd_bank_q, rd_addr_q}),
    .rd_data_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (state_q[i])
          EMPTY:    if (a_fire && wr_bank_q == 1'(i)) state_q[i] <= wr_close ? FULL : FILLING;
          FILLING:  if (wr_close && wr_bank_q == 1'(i)) state_q[i] <= FULL;
          FULL:     if (rd_issue && !rd_busy_q && rd_bank_q == 1'(i)) state_q[i] <= DRAINING;
          DRAINING: if (b_free && free_bank_q == 1'(i)) state_q[i] <= EMPTY;
          default:  state_q[i] <= EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= '0;
      wr_addr_q <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
    end else if (a_fire) begin
      if (wr_close) begin
        len_q[wr_bank_q] <= LEN_W'(wr_addr_q) + LEN_W'(1);
        wr_bank_q        <= other_bank(wr_bank_q);
        wr_addr_q        <= '0;
      end else begin
        wr_addr_q <= wr_addr_q + ADDR_W'(1);
      end
    end
  end

  // The read pointer moves on as soon as a bank's last word is issued, so the
  // next bank can start while the previous one is still in the skid buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_q   <= '0;
      rd_addr_q   <= '0;
      rd_busy_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q <= rd_issue;
      if (rd_issue) begin
        infl_last_q <= rd_issue_last;
        if (rd_issue_last) begin
          rd_addr_q <= '0;
          rd_busy_q <= 1'b0;
          rd_bank_q <= other_bank(rd_bank_q);
        end else begin
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
          rd_busy_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_data_q[0] <= '0;
      skid_data_q[1] <= '0;
      skid_last_q[0] <= 1'b0;
      skid_last_q[1] <= 1'b0;
      skid_head_q    <= 1'b0;
      skid_tail_q    <= 1'b0;
      skid_cnt_q     <= 2'd0;
      free_bank_q    <= '0;
    end else begin
      skid_cnt_q <= skid_cnt_d;
      if (infl_q) begin
        skid_data_q[skid_tail_q] <= ram_rdata;
        skid_last_q[skid_tail_q] <= infl_last_q;
        skid_tail_q              <= ~skid_tail_q;
      end
      if (b_fire) skid_head_q <= ~skid_head_q;
      if (b_free) free_bank_q <= other_bank(free_bank_q);
    end
  end

endmodule

// File: tb/tb_pingpong_burst_buf.sv
// Directed and randomised checks of the ping-pong burst buffer with a
// queue scoreboard filled on a-side accepts and drained by a b-side monitor.
module tb_pingpong_burst_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a_data = '0;
  logic        a_valid = 1'b0;
  logic        a_last = 1'b0;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_last;
  logic        b_ready = 1'b0;
  logic [1:0]  bank_full;

  pingpong_burst_buf #(.DATA_W(32), .BURST_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .bank_full (bank_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  int  last_acc_k, first_valid_cyc, first_beat_cyc, last_beat_cyc, beat_cnt;
  bit  seen_valid, rand_br;
  bit  prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // b-side monitor: every accepted beat is compared with the scoreboard head.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 64'({b_valid, b_last, b_data}), 64'({1'b1, prev_last, prev_data}));
      if (b_valid && !seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (b_valid && b_ready) begin
        $display("b beat %0d data=%08h last=%0d", beat_cnt, b_data, b_last);
        if (exp_q.size() == 0) begin
          note_fail("b_unexpected", $sformatf("got 0x%08h, expected no beat", b_data));
        end else begin
          e = exp_q.pop_front();
          chk("b_data", 64'(b_data), 64'(e[31:0]));
          chk("b_last", 64'(b_last), 64'(e[32]));
        end
        if (beat_cnt == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beat_cnt++;
      end
      prev_stall = b_valid && !b_ready;
      prev_data  = b_data;
      prev_last  = b_last;
    end
  end

  always @(posedge clk) begin
    if (rand_br) begin
      #1 b_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_reset(input string name);
    rst     = 1'b1;
    a_valid = 1'b0;
    a_last  = 1'b0;
    b_ready = 1'b0;
    exp_q.delete();
    #1;
    chk({name, "_a_ready"},   64'(a_ready),   64'd1);
    chk({name, "_b_valid"},   64'(b_valid),   64'd0);
    chk({name, "_b_last"},    64'(b_last),    64'd0);
    chk({name, "_b_data"},    64'(b_data),    64'd0);
    chk({name, "_bank_full"}, 64'(bank_full), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    seen_valid = 1'b0;
    beat_cnt   = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input logic exp_last);
    int  t = 0;
    bit  done = 1'b0;
    a_valid = 1'b1;
    a_data  = d;
    a_last  = l;
    while (!done) begin
      @(negedge clk);
      if (a_ready) begin
        exp_q.push_back({exp_last, d});
        last_acc_k = cyc + 1;
        $display("a beat data=%08h a_last=%0d", d, l);
        done = 1'b1;
      end else if (++t > 300) begin
        note_fail("a_accept_timeout", $sformatf("beat 0x%08h never accepted", d));
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_idle_b_valid"}, 64'(b_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int len;
    logic [31:0] d;
    logic lst, al;

    // Full-length bursts: second closes on beat count rather than a_last.
    do_reset("rst0");
    b_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'h10 + 32'(i), i == 3, i == 3);
    t = last_acc_k;
    for (int i = 0; i < 4; i++) send_beat(32'h20 + 32'(i), 1'b0, i == 3);
    wait_empty("t1");
    chk("t1_latency", 64'(first_valid_cyc), 64'(t + 2));
    chk("t1_gapless", 64'(last_beat_cyc - first_beat_cyc), 64'd7);
    chk("t1_beats", 64'(beat_cnt), 64'd8);

    // Early termination and single-beat burst.
    beat_cnt = 0;
    send_beat(32'hA0, 1'b0, 1'b0);
    send_beat(32'hA1, 1'b1, 1'b1);
    send_beat(32'hB0, 1'b1, 1'b1);
    wait_empty("t2");
    chk("t2_beats", 64'(beat_cnt), 64'd3);

    // Back-pressure: both banks full stalls the a-side.
    b_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(32'h10 + 32'(i), i == 3, i == 3);
    for (int i = 0; i < 4; i++) send_beat(32'h20 + 32'(i), i == 3, i == 3);
    chk("t3_a_ready_low", 64'(a_ready), 64'd0);
    chk("t3_bank_full", 64'(bank_full), 64'd3);
    repeat (10) @(posedge clk);
    #1;
    chk("t3_a_ready_held", 64'(a_ready), 64'd0);
    chk("t3_bank_full_held", 64'(bank_full), 64'd3);
    fork
      begin
        repeat (5) @(posedge clk);
        #1 b_ready = 1'b1;
      end
      for (int i = 0; i < 4; i++) send_beat(32'h30 + 32'(i), i == 3, i == 3);
    join
    wait_empty("t3");

    // Random b_ready with random burst lengths.
    rand_br = 1'b1;
    for (int b = 0; b < 100; b++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        d   = $urandom;
        lst = (i == len - 1);
        al  = lst;
        if (len == 4 && lst) al = 1'($urandom_range(0, 1));
        send_beat(d, al, lst);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_empty("t4");
    rand_br = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a fill and a drain.
    beat_cnt = 0;
    b_ready  = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'h40 + 32'(i), i == 3, i == 3);
    send_beat(32'h50, 1'b0, 1'b0);
    send_beat(32'h51, 1'b0, 1'b0);
    t = 0;
    while (beat_cnt < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (beat_cnt < 2) note_fail("t5_drain_start", "b-side never started draining");
    @(posedge clk);
    #1;
    do_reset("t5_rst");
    b_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'h30 + 32'(i), i == 3, i == 3);
    chk("t5_bank0", 64'(bank_full), 64'd1);
    wait_empty("t5");
    chk("t5_beats", 64'(beat_cnt), 64'd4);

    // Bank 0 freed on the same edge that bank 1 closes.
    do_reset("t6_rst");
    for (int i = 0; i < 4; i++) send_beat(32'h60 + 32'(i), i == 3, i == 3);
    for (int i = 0; i < 3; i++) send_beat(32'h70 + 32'(i), 1'b0, 1'b0);
    b_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(b_valid && b_last) && t < 200);
    if (!(b_valid && b_last)) begin
      note_fail("t6_last_head", "b_last never presented");
    end else begin
      chk("t6_bank_full_before", 64'(bank_full), 64'd1);
      chk("t6_a_ready_before", 64'(a_ready), 64'd1);
      a_valid = 1'b1;
      a_data  = 32'h73;
      a_last  = 1'b1;
      exp_q.push_back({1'b1, 32'h73});
      $display("a beat data=%08h a_last=1", 32'h73);
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      a_last  = 1'b0;
      @(negedge clk);
      chk("t6_bank_full_after", 64'(bank_full), 64'd2);
      chk("t6_a_ready_after", 64'(a_ready), 64'd1);
    end
    wait_empty("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
